// File: rtl/alu_cmd_sequencer.sv
// Command FIFO feeding a single-outstanding ALU sequencer with timeout and a
// valid/ready response channel.
module alu_cmd_sequencer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   input  logic [2:0]  cmd_op,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [2:0]  alu_op,
   output logic        alu_start,
   input  logic        alu_done,
   input  logic [15:0] alu_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [2:0]  rsp_op,
   output logic        rsp_err,
   output logic        busy
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e         state_q, state_d;
   logic [18:0]    mem_q [FIFO_DEPTH];
   logic [AW:0]    wr_ptr_q, rd_ptr_q;
   logic           fifo_empty, fifo_full;
   logic           push, pop;
   logic           ready_q;
   logic [7:0]     a_q, b_q;
   logic [2:0]     op_q;
   logic           start_q, start_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [15:0]    res_q, res_d;
   logic           err_q, err_d;
   logic [18:0]    head;

   // Extra pointer bit tells full from empty when the index bits match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head       = mem_q[rd_ptr_q[AW-1:0]];

   // ready_q keeps cmd_ready low until the first edge out of reset.
   assign cmd_ready  = ready_q & ~fifo_full;
   assign push       = cmd_valid & cmd_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_b, cmd_a};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      start_d = start_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            unique case (op_q)
               3'b000: begin
                  res_d   = 16'h0000;
                  err_d   = 1'b0;
                  state_d = StResp;
               end
               3'b001, 3'b010, 3'b011, 3'b100: begin
                  start_d = 1'b1;
                  cnt_d   = '0;
                  state_d = StWait;
               end
               default: begin
                  res_d   = 16'h0000;
                  err_d   = 1'b1;
                  state_d = StResp;
               end
            endcase
         end
         StWait: begin
            // Completion takes priority over a coincident timeout.
            if (alu_done) begin
               res_d   = alu_result;
               err_d   = 1'b0;
               start_d = 1'b0;
               state_d = StResp;
            end else if (cnt_q == CNT_LAST) begin
               res_d   = 16'hDEAD;
               err_d   = 1'b1;
               start_d = 1'b0;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         start_q <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         err_q   <= err_d;
         if (pop) begin
            {op_q, b_q, a_q} <= head;
         end
      end
   end

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_op     = op_q;
   assign alu_start  = start_q;
   assign rsp_valid  = (state_q == StResp);
   assign rsp_result = res_q;
   assign rsp_op     = op_q;
   assign rsp_err    = err_q;
   assign busy       = ~fifo_empty | (state_q != StIdle);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: directed commands, an ALU model with
// programmable latency, and a response monitor decoupled from stimulus.
module tb_alu_cmd_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_ready;
   logic [7:0]  cmd_a, cmd_b;
   logic [2:0]  cmd_op;
   logic [7:0]  alu_a, alu_b;
   logic [2:0]  alu_op;
   logic        alu_start, alu_done;
   logic [15:0] alu_result;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_result;
   logic [2:0]  rsp_op;
   logic        rsp_err, busy;

   typedef struct packed {
      logic [15:0] result;
      logic [2:0]  op;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   alu_lat  = 1;   // 0: ALU never completes
   int   last_len = 0;
   int   run_len  = 0;
   int   total_starts = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(15)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
      .alu_done(alu_done), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_op(rsp_op), .rsp_err(rsp_err), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic [15:0] exp_res, input logic exp_err);
      int n;
      exp_t e;
      e.result = exp_res;
      e.op     = op;
      e.err    = exp_err;
      sb.push_back(e);
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (cmd_ready) break;
         n++;
         if (n > 300) begin
            check("push_accept_timeout", 0, 1);
            break;
         end
      end
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy || rsp_valid) begin
         tick();
         n++;
         if (n > 300) begin
            check(name, 0, 1);
            break;
         end
      end
      tick();
   endtask

   // ALU model: raises done for one cycle after alu_lat cycles of alu_start.
   initial begin
      int cnt;
      cnt = 0;
      alu_done = 1'b0;
      alu_result = '0;
      forever begin
         @(negedge clk);
         if (alu_start && !alu_done) begin
            cnt++;
            if (alu_lat != 0 && cnt == alu_lat) begin
               alu_done = 1'b1;
               unique case (alu_op)
                  3'b001:  alu_result = 16'(alu_a) + 16'(alu_b);
                  3'b010:  alu_result = 16'(alu_a) - 16'(alu_b);
                  3'b011:  alu_result = 16'(alu_a & alu_b);
                  3'b100:  alu_result = 16'(alu_a) * 16'(alu_b);
                  default: alu_result = 16'h0;
               endcase
            end
         end else begin
            alu_done = 1'b0;
            cnt = 0;
         end
      end
   end

   // alu_start run length and operand stability while it is held.
   initial begin
      logic [18:0] held;
      held = '0;
      forever begin
         @(negedge clk);
         if (alu_start) begin
            run_len++;
            if (run_len == 1) begin
               total_starts++;
               held = {alu_op, alu_b, alu_a};
            end else begin
               check("alu_operands_stable", {13'b0, alu_op, alu_b, alu_a}, {13'b0, held});
            end
         end else if (run_len != 0) begin
            last_len = run_len;
            run_len = 0;
         end
      end
   end

   // Response monitor: pops the scoreboard on each handshake.
   initial begin
      exp_t e;
      exp_t held;
      logic stalled;
      stalled = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (rsp_valid && !rsp_ready) begin
            if (stalled) begin
               check("rsp_stable_stalled", {12'b0, rsp_result, rsp_op, rsp_err},
                     {12'b0, held});
            end
            held = {rsp_result, rsp_op, rsp_err};
            stalled = 1'b1;
         end else begin
            stalled = 1'b0;
         end
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               check("rsp_unexpected", 1, 0);
            end else begin
               e = sb.pop_front();
               check("rsp_result", 32'(rsp_result), 32'(e.result));
               check("rsp_op", 32'(rsp_op), 32'(e.op));
               check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int n;
      reset_n = 1'b0;
      cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
      rsp_ready = 1'b1;
      #23;
      check("reset_cmd_ready", 32'(cmd_ready), 0);
      check("reset_outputs", {alu_start, rsp_valid, busy, rsp_err, alu_a, rsp_result},
            32'h0);
      tick();
      reset_n = 1'b1;
      tick();
      check("cmd_ready_after_reset", 32'(cmd_ready), 1);

      // no_op: rsp_valid two edges after the push edge, no ALU start.
      s0 = total_starts;
      push(8'h11, 8'h22, 3'b000, 16'h0000, 1'b0);
      tick();
      check("noop_not_yet_valid", 32'(rsp_valid), 0);
      tick();
      check("noop_latency_valid", 32'(rsp_valid), 1);
      wait_idle("noop_idle_timeout");
      push(8'h33, 8'h44, 3'b110, 16'h0000, 1'b1);
      wait_idle("illegal_idle_timeout");
      check("no_start_noop_illegal", 32'(total_starts), 32'(s0));

      alu_lat = 1;
      push(8'h12, 8'h34, 3'b001, 16'h0046, 1'b0);
      wait_idle("add_idle_timeout");
      check("add_start_len", 32'(last_len), 1);

      alu_lat = 3;
      push(8'hFF, 8'hFF, 3'b100, 16'hFE01, 1'b0);
      wait_idle("mul_idle_timeout");
      check("mul_start_len", 32'(last_len), 3);

      alu_lat = 2;
      push(8'h50, 8'h20, 3'b010, 16'h0030, 1'b0);
      wait_idle("sub_idle_timeout");

      alu_lat = 0;
      push(8'h05, 8'h03, 3'b010, 16'hDEAD, 1'b1);
      wait_idle("timeout_idle_timeout");
      check("timeout_start_len", 32'(last_len), 15);
      alu_lat = 1;
      push(8'h05, 8'h03, 3'b010, 16'h0002, 1'b0);
      wait_idle("post_timeout_idle_timeout");

      // Backpressure: one in flight plus four queued fills the FIFO.
      rsp_ready = 1'b0;
      push(8'd1, 8'd1, 3'b001, 16'd2, 1'b0);
      push(8'd2, 8'd2, 3'b001, 16'd4, 1'b0);
      push(8'd3, 8'd3, 3'b001, 16'd6, 1'b0);
      push(8'd4, 8'd4, 3'b001, 16'd8, 1'b0);
      check("cmd_ready_not_full", 32'(cmd_ready), 1);
      push(8'd5, 8'd5, 3'b001, 16'd10, 1'b0);
      fork
         push(8'd6, 8'd6, 3'b001, 16'd12, 1'b0);
         begin
            repeat (6) tick();
            check("cmd_ready_full", 32'(cmd_ready), 0);
            check("rsp_valid_stalled", 32'(rsp_valid), 1);
            rsp_ready = 1'b1;
         end
      join
      wait_idle("bp_idle_timeout");
      check("bp_all_responses", 32'(sb.size()), 0);

      // Reset two cycles into a mul that never completes.
      alu_lat = 0;
      push(8'hFF, 8'hFF, 3'b100, 16'hFE01, 1'b0);
      n = 0;
      while (!alu_start && n < 20) begin
         tick();
         n++;
      end
      check("rst_wait_reached", 32'(alu_start), 1);
      tick();
      tick();
      reset_n = 1'b0;
      sb.delete();
      #1;
      check("rst_alu_start_async", 32'(alu_start), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      tick();
      reset_n = 1'b1;
      repeat (20) tick();
      check("rst_no_rsp_busy", 32'(busy), 0);
      check("rst_no_rsp_sb", 32'(sb.size()), 0);

      alu_lat = 1;
      push(8'h01, 8'h02, 3'b001, 16'h0003, 1'b0);
      wait_idle("post_reset_idle_timeout");
      check("final_sb_empty", 32'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
